// File: rtl/inv_cipher_if.sv
// Block-level bus for the iterative AES-128 inverse cipher: start/busy/done
// control, ciphertext and plaintext buses, and the round-key store lookup.
interface inv_cipher_if;
   // iStart is taken only while oBusy is low; after that the block is in flight
   // until a one-cycle oDone, which qualifies oBlockout. iKeyValue is the key
   // store's combinational answer to oKeyIdx in the same cycle.
   logic         iStart;
   logic [127:0] iBlockIn;
   logic [127:0] iKeyValue;
   logic [3:0]   oKeyIdx;
   logic         oBusy;
   logic         oDone;
   logic [127:0] oBlockout;

   modport master (output iStart, iBlockIn, iKeyValue,
                   input  oKeyIdx, oBusy, oDone, oBlockout);
   modport slave  (input  iStart, iBlockIn, iKeyValue,
                   output oKeyIdx, oBusy, oDone, oBlockout);
endinterface

// File: rtl/inv_cipher_iter.sv
// Iterative AES-128 InvCipher: one round per clock over a shared datapath,
// round keys fetched from an external store indexed by oKeyIdx (10 down to 0).
module inv_cipher_iter (
   input  logic         clk,
   input  logic         rst_n,
   inv_cipher_if.slave  bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2} state_e;

   localparam logic [3:0] LAST_KEY = 4'd10;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
   };

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul9(input logic [7:0] b);
      return xt(xt(xt(b))) ^ b;
   endfunction

   function automatic logic [7:0] mulb(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(b) ^ b;
   endfunction

   function automatic logic [7:0] muld(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
   endfunction

   function automatic logic [7:0] mule(input logic [7:0] b);
      return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
   endfunction

   // Byte 4c+r sits at bits [127-8*(4c+r) -: 8]; row r rotates right by r.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int i = 0; i < 16; i++) begin
         o[127-8*i -: 8] = INV_SBOX[s[127-8*i -: 8]];
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
         o[119-32*c -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
         o[111-32*c -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
         o[103-32*c -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
      end
      return o;
   endfunction

   state_e       state_q, state_d;
   logic [127:0] blk_q, blk_d;
   logic [3:0]   key_idx_q, key_idx_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic [127:0] blockout_q, blockout_d;
   logic [127:0] round_sub;

   always_comb begin
      state_d    = state_q;
      blk_d      = blk_q;
      key_idx_d  = key_idx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      blockout_d = blockout_q;
      // Shared by ROUND and FINAL; FINAL simply skips InvMixColumns.
      round_sub  = inv_sub_bytes(inv_shift_rows(blk_q)) ^ bus.iKeyValue;
      case (state_q)
         IDLE: begin
            key_idx_d = LAST_KEY;
            if (bus.iStart) begin
               blk_d     = bus.iBlockIn ^ bus.iKeyValue;
               key_idx_d = 4'd9;
               busy_d    = 1'b1;
               state_d   = ROUND;
            end
         end
         ROUND: begin
            blk_d     = inv_mix_columns(round_sub);
            key_idx_d = key_idx_q - 4'd1;
            if (key_idx_q == 4'd1) state_d = FINAL;
         end
         FINAL: begin
            blockout_d = round_sub;
            done_d     = 1'b1;
            busy_d     = 1'b0;
            key_idx_d  = LAST_KEY;
            state_d    = IDLE;
         end
         default: begin
            state_d   = IDLE;
            key_idx_d = LAST_KEY;
            busy_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         blk_q      <= '0;
         key_idx_q  <= LAST_KEY;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         blockout_q <= '0;
      end else begin
         state_q    <= state_d;
         blk_q      <= blk_d;
         key_idx_q  <= key_idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         blockout_q <= blockout_d;
      end
   end

   assign bus.oKeyIdx   = key_idx_q;
   assign bus.oBusy     = busy_q;
   assign bus.oDone     = done_q;
   assign bus.oBlockout = blockout_q;

endmodule

// File: tb/tb_inv_cipher_iter.sv
// Bench for inv_cipher_iter: FIPS-197 known answers, control timing, reset,
// and random blocks produced by a forward-cipher model in the bench.
module tb_inv_cipher_iter;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic         ks_sel;
   logic [127:0] rk [0:1][0:15];

   inv_cipher_if bus();

   inv_cipher_iter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Key store: combinational lookup of the selected schedule by oKeyIdx.
   assign bus.iKeyValue = rk[ks_sel][bus.oKeyIdx];

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   task automatic expand_key(input int sel, input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]], SBOX[t[31:24]]} ^ {rcon, 24'h0};
            rcon = xt(rcon);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[sel][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Forward cipher: random plaintexts are encrypted here and must come back.
   function automatic logic [127:0] encrypt(input int sel, input logic [127:0] pt);
      logic [127:0] s, t;
      logic [7:0]   a0, a1, a2, a3;
      s = pt ^ rk[sel][0];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         s = t;
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[127-32*c -: 8];
               a1 = t[119-32*c -: 8];
               a2 = t[111-32*c -: 8];
               a3 = t[103-32*c -: 8];
               s[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         s = s ^ rk[sel][rnd];
      end
      return s;
   endfunction

   task tick;
      @(posedge clk);
      #1;
   endtask

   // Accepts one block from IDLE; lat counts edges from acceptance to oDone inclusive.
   task automatic run_block(input logic sel, input logic [127:0] ct,
                            output logic [127:0] res, output int lat);
      ks_sel       = sel;
      bus.iBlockIn = ct;
      bus.iStart   = 1'b1;
      tick();
      bus.iStart   = 1'b0;
      bus.iBlockIn = '0;
      lat = -1;
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (bus.oDone) begin
            lat = n + 1;
            break;
         end
      end
      res = bus.oBlockout;
   endtask

   task automatic test_reset;
      rst_n        = 1'b0;
      bus.iStart   = 1'b0;
      bus.iBlockIn = '0;
      ks_sel       = 1'b0;
      repeat (2) tick();
      checks++; if (bus.oKeyIdx !== 4'd10) begin errors++; $display("FAIL reset_keyidx: got %0d expected 10", bus.oKeyIdx); end
      checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.oBusy); end
      checks++; if (bus.oDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.oDone); end
      checks++; if (bus.oBlockout !== 128'h0) begin errors++; $display("FAIL reset_blockout: got %h expected 0", bus.oBlockout); end
      rst_n = 1'b1;
      repeat (2) tick();
      checks++; if (bus.oBusy !== 1'b0 || bus.oKeyIdx !== 4'd10) begin errors++; $display("FAIL idle_hold: got busy %b idx %0d expected 0/10", bus.oBusy, bus.oKeyIdx); end
   endtask

   task automatic test_c1;
      logic [127:0] res;
      int           lat;
      run_block(1'b0, C1_CT, res, lat);
      checks++; if (res !== C1_PT) begin errors++; $display("FAIL c1_result: got %h expected %h", res, C1_PT); end
      checks++; if (lat !== 11) begin errors++; $display("FAIL c1_latency: got %0d expected 11", lat); end
      checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL c1_busy_at_done: got %b expected 0", bus.oBusy); end
      checks++; if (bus.oKeyIdx !== 4'd10) begin errors++; $display("FAIL c1_idx_at_done: got %0d expected 10", bus.oKeyIdx); end
      tick();
      checks++; if (bus.oDone !== 1'b0) begin errors++; $display("FAIL c1_done_pulse: got %b expected 0", bus.oDone); end
      checks++; if (bus.oBlockout !== C1_PT) begin errors++; $display("FAIL c1_hold: got %h expected %h", bus.oBlockout, C1_PT); end
   endtask

   task automatic test_b_sequence;
      logic [3:0] exp_idx;
      ks_sel       = 1'b1;
      bus.iBlockIn = B_CT;
      checks++; if (bus.oKeyIdx !== 4'd10) begin errors++; $display("FAIL b_idx_pre: got %0d expected 10", bus.oKeyIdx); end
      bus.iStart = 1'b1;
      tick();
      bus.iStart   = 1'b0;
      bus.iBlockIn = '0;
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) tick();
         exp_idx = (k == 10) ? 4'd10 : 4'(9 - k);
         checks++; if (bus.oKeyIdx !== exp_idx) begin errors++; $display("FAIL b_idx_e%0d: got %0d expected %0d", k, bus.oKeyIdx, exp_idx); end
         checks++; if (bus.oBusy !== (k < 10)) begin errors++; $display("FAIL b_busy_e%0d: got %b expected %b", k, bus.oBusy, (k < 10)); end
         checks++; if (bus.oDone !== (k == 10)) begin errors++; $display("FAIL b_done_e%0d: got %b expected %b", k, bus.oDone, (k == 10)); end
      end
      checks++; if (bus.oBlockout !== B_PT) begin errors++; $display("FAIL b_result: got %h expected %h", bus.oBlockout, B_PT); end
   endtask

   task automatic test_start_while_busy;
      int           done_cnt;
      int           done_edge;
      logic [127:0] res;
      done_cnt  = 0;
      done_edge = -1;
      res       = '0;
      ks_sel       = 1'b0;
      bus.iBlockIn = C1_CT;
      bus.iStart   = 1'b1;
      tick();
      bus.iStart = 1'b0;
      repeat (2) tick();
      bus.iStart   = 1'b1;
      bus.iBlockIn = B_CT;
      tick();
      bus.iStart = 1'b0;
      checks++; if (bus.oKeyIdx !== 4'd6) begin errors++; $display("FAIL busy_start_idx: got %0d expected 6", bus.oKeyIdx); end
      for (int e = 4; e <= 20; e++) begin
         tick();
         if (bus.oDone) begin
            done_cnt++;
            done_edge = e;
            res = bus.oBlockout;
         end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt); end
      checks++; if (done_edge !== 10) begin errors++; $display("FAIL busy_start_done_edge: got %0d expected 10", done_edge); end
      checks++; if (res !== C1_PT) begin errors++; $display("FAIL busy_start_result: got %h expected %h", res, C1_PT); end
      checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL busy_start_no_accept: got %b expected 0", bus.oBusy); end
   endtask

   task automatic test_back_to_back;
      int           first_e, second_e, extra, hold_bad;
      logic [127:0] res1, res2;
      first_e = -1; second_e = -1; extra = 0; hold_bad = 0;
      res1 = '0; res2 = '0;
      ks_sel       = 1'b0;
      bus.iBlockIn = C1_CT;
      bus.iStart   = 1'b1;
      tick();
      bus.iBlockIn = B_CT;
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (bus.oDone) begin
            if (first_e < 0) begin
               first_e = e;
               res1    = bus.oBlockout;
               ks_sel  = 1'b1;
            end else if (second_e < 0) begin
               second_e   = e;
               res2       = bus.oBlockout;
               bus.iStart = 1'b0;
            end else begin
               extra++;
            end
         end else if (first_e >= 0 && second_e < 0 && bus.oBlockout !== C1_PT) begin
            hold_bad++;
         end
      end
      bus.iStart = 1'b0;
      checks++; if (first_e !== 10) begin errors++; $display("FAIL b2b_first_edge: got %0d expected 10", first_e); end
      // Next acceptance is E11, so the second pulse trails the first by 11 edges.
      checks++; if (second_e - first_e !== 11) begin errors++; $display("FAIL b2b_spacing: got %0d expected 11", second_e - first_e); end
      checks++; if (res1 !== C1_PT) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", res1, C1_PT); end
      checks++; if (res2 !== B_PT) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", res2, B_PT); end
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL b2b_hold: got %0d changes expected 0", hold_bad); end
      checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra_done: got %0d expected 0", extra); end
   endtask

   task automatic test_reset_mid;
      int           done_cnt;
      logic [127:0] res;
      int           lat;
      done_cnt     = 0;
      ks_sel       = 1'b0;
      bus.iBlockIn = C1_CT;
      bus.iStart   = 1'b1;
      tick();
      bus.iStart = 1'b0;
      repeat (4) tick();
      #3 rst_n = 1'b0;
      #1;
      checks++; if (bus.oBusy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus.oBusy); end
      checks++; if (bus.oDone !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", bus.oDone); end
      checks++; if (bus.oBlockout !== 128'h0) begin errors++; $display("FAIL midrst_blockout: got %h expected 0", bus.oBlockout); end
      checks++; if (bus.oKeyIdx !== 4'd10) begin errors++; $display("FAIL midrst_idx: got %0d expected 10", bus.oKeyIdx); end
      repeat (2) tick();
      rst_n = 1'b1;
      for (int e = 0; e < 15; e++) begin
         tick();
         if (bus.oDone) done_cnt++;
      end
      checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", done_cnt); end
      run_block(1'b0, C1_CT, res, lat);
      checks++; if (res !== C1_PT) begin errors++; $display("FAIL midrst_rerun_result: got %h expected %h", res, C1_PT); end
      checks++; if (lat !== 11) begin errors++; $display("FAIL midrst_rerun_latency: got %0d expected 11", lat); end
   endtask

   task automatic test_random;
      logic [127:0] key, pt, ct, res;
      int           lat;
      for (int it = 0; it < 1000; it++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         expand_key(1, key);
         ct = encrypt(1, pt);
         repeat ($urandom_range(0, 3)) tick();
         run_block(1'b1, ct, res, lat);
         checks++; if (res !== pt) begin errors++; $display("FAIL rand%0d_result: got %h expected %h", it, res, pt); end
         checks++; if (lat !== 11) begin errors++; $display("FAIL rand%0d_latency: got %0d expected 11", it, lat); end
         tick();
         checks++; if (bus.oDone !== 1'b0) begin errors++; $display("FAIL rand%0d_single_done: got %b expected 0", it, bus.oDone); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int s = 0; s < 2; s++)
         for (int r = 11; r < 16; r++) rk[s][r] = '0;
      expand_key(0, C1_KEY);
      expand_key(1, B_KEY);
      test_reset();
      test_c1();
      test_b_sequence();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
